// File: rtl/truth_table_scanner_pkg.sv
// Shared encodings for the truth-table scanner and any checker that
// evaluates the same term masks.
package tt_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic MODE_SOP = 1'b0;
    localparam logic MODE_POS = 1'b1;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } tt_state_e;

endpackage

// File: rtl/truth_table_scanner_term_eval.sv
// Combinational evaluation of one truth-table row from a minterm (SoP)
// or maxterm (PoS) mask.
module term_eval
    import tt_pkg::*;
#(
    parameter  int N     = 4,
    localparam int TABLE = 2**N
) (
    input  logic [TABLE-1:0] mask,
    input  logic             mode,
    input  logic [N-1:0]     idx,
    output logic             f
);

    // A listed maxterm is a row where the function is 0.
    always_comb f = (mode == MODE_POS) ? ~mask[idx] : mask[idx];

endmodule

// File: rtl/truth_table_scanner.sv
// Walks all 2^N rows of a programmable Boolean function and streams
// (index, value) pairs, counting accepted rows whose value is 1.
module truth_table_scanner
    import tt_pkg::*;
#(
    parameter  int N     = 4,
    localparam int TABLE = 2**N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [TABLE-1:0] mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_idx,
    output logic             out_val,
    output logic             busy,
    output logic             done,
    output logic [N:0]       ones_count,
    output logic [1:0]       dbg_state
);

    localparam logic [N-1:0] IDX_ONE = N'(1);

    tt_state_e        state_q;
    logic [N-1:0]     idx_q;
    logic [N-1:0]     idx_d;
    logic [N:0]       ones_q;
    logic [N:0]       ones_d;
    logic [TABLE-1:0] mask_q;
    logic             mode_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             f;
    logic             xfer;

    term_eval #(.N(N)) u_term_eval (
        .mask (mask_q),
        .mode (mode_q),
        .idx  (idx_q),
        .f    (f)
    );

    // Handshake: a pair moves only on a cycle with out_valid & out_ready;
    // until then out_idx/out_val hold, and a pair offered alongside abort
    // is dropped uncounted.
    assign xfer   = valid_q & out_ready;
    assign idx_d  = idx_q + IDX_ONE;
    assign ones_d = ones_q + {{N{1'b0}}, f};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ones_q  <= '0;
            mask_q  <= '0;
            mode_q  <= MODE_SOP;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mask_q  <= mask;
                        mode_q  <= mode;
                        idx_q   <= '0;
                        ones_q  <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (xfer) begin
                        ones_q <= ones_d;
                        if (idx_q == '1) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid  = valid_q;
    assign out_idx    = idx_q;
    assign out_val    = valid_q & f;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ones_count = ones_q;
    assign dbg_state  = state_q;

endmodule
